mips_mem_arbiter: RTL

- Shares one single-port bus memory (Avalon-style, with waitrequest) between the CPU instruction-fetch port and the data load/store port.
- Lets the existing Harvard core run against a unified bus memory.
- Data accesses have priority. A starvation counter guarantees forward progress for fetches.
- Sits between the CPU core and the bus memory/testbench RAM.

---
 rtl/mips_mem_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
//   Shares one single-port Avalon-style bus memory between the CPU fetch
//   port and the data load/store port. Data has priority. A starvation
//   counter forces a fetch grant after STARVE_LIMIT consecutive data grants
//   that were made while a fetch was waiting.
//
// Ports
//   clk, reset          : system clock (rising edge), async active-low reset
//   instr_req/addr      : fetch request, held until instr_valid
//   instr_rdata/valid   : fetched word and its one-cycle completion pulse
//   instr_stall         : fetch pending and not completing this cycle
//   data_read/write     : load/store request, held until data_valid
//   data_addr/wdata/byteenable : load/store address, store data, byte lanes
//   data_rdata/valid    : load result and one-cycle completion pulse
//   data_stall          : load/store pending and not completing this cycle
//   mem_*               : bus master side; a transfer completes on a rising
//                         edge where mem_waitrequest is 0
//
// State   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transfer on the bus; arbitration happens at the next edge
// BUSY_I  | fetch read on the bus, waiting for mem_waitrequest=0
// BUSY_D  | load or store on the bus, waiting for mem_waitrequest=0

module mips_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_valid,
  output logic        instr_stall,

  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        data_stall,

  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] starve_cnt;

  logic instr_elig;
  logic data_elig;
  logic grant_i;
  logic grant_d;

  // A requester whose valid pulse is high this cycle is still holding its
  // request only because it has not yet seen the completion; mask it.
  assign instr_elig = instr_req & ~instr_valid;
  assign data_elig  = (data_read | data_write) & ~data_valid;

  assign grant_i = instr_elig & (~data_elig | (starve_cnt == STARVE_MAX));
  assign grant_d = data_elig & ~grant_i;

  assign instr_stall = instr_req & ~instr_valid;
  assign data_stall  = (data_read | data_write) & ~data_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      starve_cnt     <= 4'd0;
      mem_address    <= 32'd0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= 32'd0;
      mem_byteenable <= 4'd0;
      instr_rdata    <= 32'd0;
      data_rdata     <= 32'd0;
      instr_valid    <= 1'b0;
      data_valid     <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      data_valid  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (grant_i) begin
            state          <= BUSY_I;
            starve_cnt     <= 4'd0;
            mem_address    <= instr_addr;
            mem_read       <= 1'b1;
            mem_write      <= 1'b0;
            mem_byteenable <= 4'hF;
          end else if (grant_d) begin
            state          <= BUSY_D;
            mem_address    <= data_addr;
            mem_writedata  <= data_wdata;
            mem_byteenable <= data_byteenable;
            // A store wins when both strobes are requested together.
            mem_write      <= data_write;
            mem_read       <= data_read & ~data_write;
            if (!instr_elig) begin
              starve_cnt <= 4'd0;
            end else if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end

        BUSY_I: begin
          if (!mem_waitrequest) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            instr_rdata <= mem_readdata;
            instr_valid <= 1'b1;
          end
        end

        BUSY_D: begin
          if (!mem_waitrequest) begin
            state      <= IDLE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            data_valid <= 1'b1;
            if (mem_read) begin
              data_rdata <= mem_readdata;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
